// File: rtl/sr_latch_sync.sv
// Bank of WIDTH clocked NOR-style SR cells with a synchronous reset.
// A cell that leaves the s=r=1 state through s=r=0 settles to the cleared state.
module sr_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qn,
  output logic illegal
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RESET_VAL;
      qn      <= ~RESET_VAL;
      illegal <= 1'b0;
    end else begin
      unique case ({s, r})
        2'b10: begin
          q       <= 1'b1;
          qn      <= 1'b0;
          illegal <= 1'b0;
        end
        2'b01: begin
          q       <= 1'b0;
          qn      <= 1'b1;
          illegal <= 1'b0;
        end
        2'b11: begin
          q       <= 1'b0;
          qn      <= 1'b0;
          illegal <= 1'b1;
        end
        default: begin
          // Hold; an illegal cell resolves to the cleared state instead of racing.
          if (illegal) begin
            q       <= 1'b0;
            qn      <= 1'b1;
            illegal <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

module sr_latch_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] illegal,
  output logic             illegal_any
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(.RESET_VAL(RESET_VAL[i])) u_cell (
      .clk     (clk),
      .rst     (rst),
      .s       (s[i]),
      .r       (r[i]),
      .q       (q[i]),
      .qn      (qn[i]),
      .illegal (illegal[i])
    );
  end

  assign illegal_any = |illegal;

endmodule

// File: tb/tb_sr_latch_sync.sv
// Bench for sr_latch_sync: a 1-bit and a 4-bit instance checked against a rule-level model.
module tb_sr_latch_sync;

  localparam logic [3:0] RV4 = 4'b1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b0, s1 = 1'b0, r1 = 1'b0;
  logic       q1, qn1, il1, ila1;
  logic       rst4 = 1'b0;
  logic [3:0] s4 = '0, r4 = '0;
  logic [3:0] q4, qn4, il4;
  logic       ila4;

  sr_latch_sync #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .s(s1), .r(r1),
    .q(q1), .qn(qn1), .illegal(il1), .illegal_any(ila1)
  );

  sr_latch_sync #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (
    .clk(clk), .rst(rst4), .s(s4), .r(r4),
    .q(q4), .qn(qn4), .illegal(il4), .illegal_any(ila4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: stored q and whether the cell sits in the s=r=1 state.
  logic       mq1, mil1;
  logic [3:0] mq4, mil4;

  function automatic void cell_rule(input logic rst, input logic rv, input logic s,
                                    input logic r, inout logic q, inout logic il);
    if (rst)         begin q = rv;   il = 1'b0; end
    else if (s && r) begin q = 1'b0; il = 1'b1; end
    else if (s)      begin q = 1'b1; il = 1'b0; end
    else if (r)      begin q = 1'b0; il = 1'b0; end
    else if (il)     begin q = 1'b0; il = 1'b0; end
  endfunction

  // One rising edge with the currently driven inputs; model follows, then settle.
  task automatic tick();
    logic q, il;
    @(posedge clk);
    q = mq1; il = mil1;
    cell_rule(rst1, 1'b0, s1, r1, q, il);
    mq1 = q; mil1 = il;
    for (int i = 0; i < 4; i++) begin
      q = mq4[i]; il = mil4[i];
      cell_rule(rst4, RV4[i], s4[i], r4[i], q, il);
      mq4[i] = q; mil4[i] = il;
    end
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; s1 = 1'b1; r1 = 1'b0;
    rst4 = 1'b1; s4 = 4'($urandom); r4 = 4'($urandom);
    tick();
    rst1 = 1'b0; rst4 = 1'b0; s1 = 1'b0; s4 = '0; r4 = '0;
    n_checks++;
    if ({q1, qn1, il1, ila1} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_w1: got q/qn/il/any=%b%b%b%b want 0100", q1, qn1, il1, ila1);
    end
    n_checks++;
    if ({q4, qn4, il4, ila4} !== {4'b1010, 4'b0101, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_w4: got q=%b qn=%b il=%b any=%b want 1010 0101 0000 0", q4, qn4, il4, ila4);
    end
  endtask

  task automatic test_w1_sequence();
    s1 = 1'b1; r1 = 1'b0; tick();
    n_checks++;
    if ({q1, qn1, il1} !== 3'b100) begin
      n_fail++; $display("FAIL w1_set: got %b%b%b want 100", q1, qn1, il1);
    end
    s1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({q1, qn1, il1} !== 3'b100) begin
        n_fail++; $display("FAIL w1_hold_set[%0d]: got %b%b%b want 100", k, q1, qn1, il1);
      end
    end
    r1 = 1'b1; tick();
    n_checks++;
    if ({q1, qn1, il1} !== 3'b010) begin
      n_fail++; $display("FAIL w1_reset: got %b%b%b want 010", q1, qn1, il1);
    end
    r1 = 1'b0; tick(); tick();
    n_checks++;
    if ({q1, qn1, il1} !== 3'b010) begin
      n_fail++; $display("FAIL w1_hold_reset: got %b%b%b want 010", q1, qn1, il1);
    end
    s1 = 1'b1; r1 = 1'b1; tick(); tick();
    n_checks++;
    if ({q1, qn1, il1, ila1} !== 4'b0011) begin
      n_fail++; $display("FAIL w1_illegal: got %b%b%b%b want 0011", q1, qn1, il1, ila1);
    end
    s1 = 1'b0; r1 = 1'b0; tick();
    n_checks++;
    if ({q1, qn1, il1, ila1} !== 4'b0100) begin
      n_fail++; $display("FAIL w1_illegal_resolve: got %b%b%b%b want 0100", q1, qn1, il1, ila1);
    end
    s1 = 1'b1; r1 = 1'b1; tick();
    s1 = 1'b1; r1 = 1'b0; tick();
    n_checks++;
    if ({q1, qn1, il1} !== 3'b100) begin
      n_fail++; $display("FAIL w1_illegal_to_set: got %b%b%b want 100", q1, qn1, il1);
    end
    s1 = 1'b0;
  endtask

  task automatic test_w4_sequence();
    s4 = 4'b0001; r4 = 4'b0110; tick();
    n_checks++;
    if ({q4, qn4, il4} !== {4'b1001, 4'b0110, 4'b0000}) begin
      n_fail++; $display("FAIL w4_mixed: got q=%b qn=%b il=%b want 1001 0110 0000", q4, qn4, il4);
    end
    s4 = 4'b1111; r4 = 4'b0100; tick();
    n_checks++;
    if ({q4, qn4, il4, ila4} !== {4'b1011, 4'b0000, 4'b0100, 1'b1}) begin
      n_fail++; $display("FAIL w4_partial_illegal: got q=%b qn=%b il=%b any=%b want 1011 0000 0100 1", q4, qn4, il4, ila4);
    end
    s4 = 4'b0000; r4 = 4'b0000; tick();
    n_checks++;
    if ({q4, qn4, il4, ila4} !== {4'b1011, 4'b0100, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL w4_resolve: got q=%b qn=%b il=%b any=%b want 1011 0100 0000 0", q4, qn4, il4, ila4);
    end
  endtask

  task automatic test_reset_from_illegal();
    s4 = 4'b1111; r4 = 4'b1111; tick();
    n_checks++;
    if ({q4, qn4, il4, ila4} !== {4'b0000, 4'b0000, 4'b1111, 1'b1}) begin
      n_fail++; $display("FAIL w4_all_illegal: got q=%b qn=%b il=%b any=%b want 0000 0000 1111 1", q4, qn4, il4, ila4);
    end
    rst4 = 1'b1; tick();
    rst4 = 1'b0; s4 = '0; r4 = '0;
    n_checks++;
    if ({q4, qn4, il4, ila4} !== {4'b1010, 4'b0101, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL w4_rst_over_illegal: got q=%b qn=%b il=%b any=%b want 1010 0101 0000 0", q4, qn4, il4, ila4);
    end
  endtask

  task automatic test_random();
    logic [3:0] eqn4;
    for (int k = 0; k < 300; k++) begin
      rst1 = ($urandom_range(0, 15) == 0);
      rst4 = ($urandom_range(0, 15) == 0);
      s1 = 1'($urandom); r1 = 1'($urandom);
      s4 = 4'($urandom); r4 = 4'($urandom);
      tick();
      n_checks++;
      if ({q1, qn1, il1, ila1} !== {mq1, ~(mq1 | mil1), mil1, mil1}) begin
        n_fail++;
        $display("FAIL rand_w1[%0d]: got q/qn/il/any=%b%b%b%b want %b%b%b%b", k, q1, qn1, il1, ila1,
                 mq1, ~(mq1 | mil1), mil1, mil1);
      end
      eqn4 = ~(mq4 | mil4);
      n_checks++;
      if ({q4, qn4, il4, ila4} !== {mq4, eqn4, mil4, |mil4}) begin
        n_fail++;
        $display("FAIL rand_w4[%0d]: got q=%b qn=%b il=%b any=%b want %b %b %b %b", k, q4, qn4, il4, ila4,
                 mq4, eqn4, mil4, |mil4);
      end
    end
    rst1 = 1'b0; rst4 = 1'b0;
  endtask

  initial begin
    mq1 = 1'bx; mil1 = 1'bx; mq4 = 'x; mil4 = 'x;
    test_reset();
    test_w1_sequence();
    test_w4_sequence();
    test_reset_from_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
